// File: rtl/fb_video_pkg.sv
// Shared timing defaults, frame geometry and pipeline types for the frame-buffer video reader.
package fb_video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL         = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL         = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int WORDS_PER_LINE  = H_ACTIVE_DEF / 4;
    localparam int WORDS_PER_FRAME = WORDS_PER_LINE * V_ACTIVE_DEF;
    localparam int PIPE_LAT        = 3;
    localparam int CNT_W           = 12;

    // Per-pixel side information travelling alongside the RAM read.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       en;
        logic       tp;
        logic [1:0] lane;
        logic [7:0] hx;
        logic [7:0] vy;
    } pix_ctl_t;

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fb_video_reader_if.sv
// RAM read port plus video output bundle of the frame-buffer reader.
interface fb_video_reader_if #(parameter int ADDR_W = 17);

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              enable;
    logic              test_pat;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              frame_start;

    modport master (
        output ram_addr, red, green, blue, hsync, vsync, de, frame_start,
        input  ram_data, enable, test_pat
    );

    modport slave (
        input  ram_addr, red, green, blue, hsync, vsync, de, frame_start,
        output ram_data, enable, test_pat
    );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters with raw active-high active/hsync/vsync/frame-start flags for the current position.
module video_timing_gen
    import fb_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] h_lo_o,
    output logic [7:0] v_lo_o,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_start_o
);

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
        end
    end

    assign h_lo_o        = h_q[7:0];
    assign v_lo_o        = v_q[7:0];
    assign active_o      = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hsync_o       = (h_q >= H_SS_C) && (h_q < H_SE_C);
    assign vsync_o       = (v_q >= V_SS_C) && (v_q < V_SE_C);
    assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/fb_video_reader.sv
// Frame-buffer scan-out: raster timing, RAM word addressing, byte-lane select and aligned video outputs.
// Optional test pattern (h, v, h^v) is built in when FB_VIDEO_TEST_PATTERN_EN is defined.
module fb_video_reader
    import fb_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int ADDR_W   = 17,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic              pixclk,
    input  logic              reset,
    fb_video_reader_if.master vid
);

    localparam int                WPF     = (H_ACTIVE / 4) * V_ACTIVE;
    localparam logic [ADDR_W-1:0] WP_LAST = ADDR_W'(WPF - 1);

    logic [7:0] h_lo, v_lo;
    logic       active, hs_raw, vs_raw, fs_raw;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i         (pixclk),
        .rst_i         (reset),
        .h_lo_o        (h_lo),
        .v_lo_o        (v_lo),
        .active_o      (active),
        .hsync_o       (hs_raw),
        .vsync_o       (vs_raw),
        .frame_start_o (fs_raw)
    );

    logic [ADDR_W-1:0] wp_q, wp_d, wp_cur, addr_q;
    logic              en_frame_q, en_frame_d, tp_frame_q, tp_frame_d;
    pix_ctl_t          ctl_d;
    pix_ctl_t          ctl_q [PIPE_LAT-1];

    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d, pix;
    logic       hs_q, vs_q, de_q, fs_q;

    // Frame-level controls are latched at (0,0); that pixel already uses the new values.
    always_comb begin
        wp_cur     = fs_raw ? '0 : wp_q;
        wp_d       = wp_cur;
        if (active && (h_lo[1:0] == 2'd3) && (wp_cur != WP_LAST))
            wp_d = wp_cur + 1'b1;
        en_frame_d = fs_raw ? vid.enable : en_frame_q;
`ifdef FB_VIDEO_TEST_PATTERN_EN
        tp_frame_d = fs_raw ? vid.test_pat : tp_frame_q;
`else
        tp_frame_d = 1'b0;
`endif
        ctl_d      = '{de: active, hs: hs_raw, vs: vs_raw, fs: fs_raw, en: en_frame_d,
                       tp: tp_frame_d, lane: h_lo[1:0], hx: h_lo, vy: v_lo};
    end

`ifndef FB_VIDEO_TEST_PATTERN_EN
    logic unused_test_pat;
    assign unused_test_pat = vid.test_pat;
`endif

    // Last stage lines up with the registered RAM read data.
    always_comb begin
        pix     = sel_byte(vid.ram_data, ctl_q[PIPE_LAT-2].lane);
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (ctl_q[PIPE_LAT-2].de && ctl_q[PIPE_LAT-2].en) begin
            if (ctl_q[PIPE_LAT-2].tp) begin
                red_d   = ctl_q[PIPE_LAT-2].hx;
                green_d = ctl_q[PIPE_LAT-2].vy;
                blue_d  = ctl_q[PIPE_LAT-2].hx ^ ctl_q[PIPE_LAT-2].vy;
            end else begin
                red_d   = pix;
                green_d = pix;
                blue_d  = pix;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            wp_q       <= '0;
            addr_q     <= '0;
            en_frame_q <= 1'b0;
            tp_frame_q <= 1'b0;
            for (int i = 0; i < PIPE_LAT - 1; i++) ctl_q[i] <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hs_q       <= ~SYNC_ACT;
            vs_q       <= ~SYNC_ACT;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            addr_q     <= wp_cur;
            en_frame_q <= en_frame_d;
            tp_frame_q <= tp_frame_d;
            ctl_q[0]   <= ctl_d;
            for (int i = 1; i < PIPE_LAT - 1; i++) ctl_q[i] <= ctl_q[i-1];
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            hs_q       <= ctl_q[PIPE_LAT-2].hs ? SYNC_ACT : ~SYNC_ACT;
            vs_q       <= ctl_q[PIPE_LAT-2].vs ? SYNC_ACT : ~SYNC_ACT;
            de_q       <= ctl_q[PIPE_LAT-2].de;
            fs_q       <= ctl_q[PIPE_LAT-2].fs;
        end
    end

    assign vid.ram_addr    = addr_q;
    assign vid.red         = red_q;
    assign vid.green       = green_q;
    assign vid.blue        = blue_q;
    assign vid.hsync       = hs_q;
    assign vid.vsync       = vs_q;
    assign vid.de          = de_q;
    assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_fb_video_reader.sv
// Scoreboard bench for fb_video_reader on a shrunken raster (24x10) so several frames fit in a short run.
module tb_fb_video_reader;

    localparam int HA = 16, HFP = 2, HS = 4, HB = 2;
    localparam int VA = 6,  VFP = 1, VS = 2, VB = 1;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FT = HT * VT;
    localparam int WPF = (HA / 4) * VA;
    localparam bit SA = 1'b0;

    logic pixclk = 1'b0;
    logic reset;
    always #5 pixclk = ~pixclk;

    fb_video_reader_if #(.ADDR_W(17)) vif ();

    fb_video_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .ADDR_W(17), .SYNC_ACT(SA)
    ) dut (
        .pixclk (pixclk),
        .reset  (reset),
        .vid    (vif.master)
    );

    logic [31:0] mem [WPF];
    always @(posedge pixclk)
        vif.ram_data <= (int'(vif.ram_addr) < WPF) ? mem[vif.ram_addr] : 32'hDEAD_BEEF;

    typedef struct {
        logic       de, hs, vs, fs;
        logic [7:0] r, g, b;
    } exp_t;

    exp_t q[$];
    int   n = 0;
    bit   fen = 1'b0, ftp = 1'b0;
    int   exp_addr = 0;
    bit   addr_armed = 1'b0;
    int   cmp_cnt = 0, err_cnt = 0;
    int   de_seen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            if (err_cnt <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: every output is a pure function of the raster position reached since reset.
    always @(posedge pixclk) begin
        exp_t e;
        int x, y, pre, w;
        if (reset) begin
            q.delete();
            e = '{de: 1'b0, hs: ~SA, vs: ~SA, fs: 1'b0, r: 8'h0, g: 8'h0, b: 8'h0};
            repeat (3) q.push_back(e);
            n = 0;
            exp_addr = 0;
            addr_armed = 1'b1;
        end else begin
            x = n % HT;
            y = (n / HT) % VT;
            if (x == 0 && y == 0) begin
                fen = vif.enable;
`ifdef FB_VIDEO_TEST_PATTERN_EN
                ftp = vif.test_pat;
`else
                ftp = 1'b0;
`endif
            end
            e.de = (x < HA) && (y < VA);
            e.hs = (x >= HA + HFP && x < HA + HFP + HS) ? SA : ~SA;
            e.vs = (y >= VA + VFP && y < VA + VFP + VS) ? SA : ~SA;
            e.fs = (x == 0 && y == 0);
            e.r = 8'h0; e.g = 8'h0; e.b = 8'h0;
            if (e.de && fen) begin
                if (ftp) begin
                    e.r = 8'(x); e.g = 8'(y); e.b = 8'(x ^ y);
                end else begin
                    e.r = 8'(mem[y * (HA / 4) + x / 4] >> (8 * (x % 4)));
                    e.g = e.r; e.b = e.r;
                end
            end
            q.push_back(e);
            pre = (y < VA) ? y * HA + ((x < HA) ? x : HA) : HA * VA;
            w = pre / 4;
            exp_addr = (w > WPF - 1) ? WPF - 1 : w;
            n++;
        end
    end

    always @(negedge pixclk) begin
        exp_t e;
        if (addr_armed) check("ram_addr", 32'(vif.ram_addr), 32'(exp_addr));
        if (q.size() > 0) begin
            e = q.pop_front();
            check("de", 32'(vif.de), 32'(e.de));
            check("hsync", 32'(vif.hsync), 32'(e.hs));
            check("vsync", 32'(vif.vsync), 32'(e.vs));
            check("frame_start", 32'(vif.frame_start), 32'(e.fs));
            check("red", 32'(vif.red), 32'(e.r));
            check("green", 32'(vif.green), 32'(e.g));
            check("blue", 32'(vif.blue), 32'(e.b));
            if (vif.de === 1'b1 && de_seen < 8) begin
                check("first8_red", 32'(vif.red), 32'(8'h11 * (de_seen + 1)));
                check("first8_blue", 32'(vif.blue), 32'(8'h11 * (de_seen + 1)));
                de_seen++;
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge pixclk);
    endtask

    initial begin
        reset        = 1'b1;
        vif.enable   = 1'b1;
        vif.test_pat = 1'b0;
        for (int i = 0; i < WPF; i++) mem[i] = $urandom;
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;
        cycles(5);
        reset = 1'b0;
        cycles(2 * FT);
        cycles(3 * HT + 5);
        vif.enable = 1'b0;
        cycles(FT);
        vif.enable = 1'b1;
        cycles(2 * FT);
        cycles(4 * HT + 10);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(FT + 10);
        vif.test_pat = 1'b1;
        cycles(2 * FT);
        vif.test_pat = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycles($urandom_range(20, 400));
            case ($urandom_range(0, 3))
                0: vif.enable = ~vif.enable;
                1: vif.test_pat = ~vif.test_pat;
                2: begin
                    reset = 1'b1;
                    cycles($urandom_range(1, 3));
                    reset = 1'b0;
                end
                default: vif.enable = 1'($urandom);
            endcase
        end
        vif.enable = 1'b1;
        cycles(FT + 5);
        if (de_seen < 8) check("first8_count", 32'(de_seen), 32'd8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fb_video_reader.md
Name: fb_video_reader

Overview:
- Downstream of the dual-clock frame-buffer RAM; upstream of the HDMI transceiver. Runs in the pixclk domain.
- Generates 640x480@60 raster timing and issues RAM read addresses; each 32-bit RAM word holds four 8-bit grey pixels.
- Compensates for the RAM's 1-cycle registered read, selects the byte lane, and outputs grey RGB with aligned hsync/vsync/de.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- ADDR_W, 17, RAM word-address width
- SYNC_ACT, 0, active level of hsync/vsync

Ports:
- pixclk  in  1  pixel clock, single clock domain
- reset  in  1  synchronous, active-high reset
- ram_addr  out  ADDR_W  RAM port-B word address
- ram_data  in  32  RAM read data; valid 1 cycle after ram_addr
- enable  in  1  video enable, sampled at frame start
- test_pat  in  1  test-pattern request, sampled at frame start
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- frame_start  out  1  1-cycle pulse, aligned to output pixel (0,0)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: h_cnt=0, v_cnt=0, ram_addr=0, red/green/blue=0, de=0, frame_start=0, hsync=vsync=!SYNC_ACT, internal pipeline cleared.
- Counters:
  - H_TOTAL=800, V_TOTAL=525.
  - h_cnt wraps from 799 to 0; on that wrap v_cnt increments and wraps from 524 to 0.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync windows:
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vsync asserted for v_cnt in [490,492).
- Pipeline, cycle t = counter state (h,v):
  - t+1: ram_addr holds word pointer wp for that pixel.
  - t+2: ram_data valid.
  - t+3: red/green/blue, de, hsync, vsync, frame_start registered out.
  - Timing signals pass through exactly 3 register stages so all outputs are co-aligned. Fixed latency is 3 cycles.
- Word pointer wp:
  - Cleared to 0 when (h,v)=(0,0).
  - Increments by 1 after an active pixel with h[1:0]=3, so a frame spans 0..76799.
  - Holds its value outside the active region.
  - No increment past 76799; it restarts at 0 on the next frame.
- Byte lane:
  - lane = h[1:0] of the pixel, delayed 2 stages.
  - lane 0 selects [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
  - red=green=blue=selected byte.
- Blanking: when de=0, red/green/blue=0.
- enable:
  - Latched only at (h,v)=(0,0) into en_frame.
  - en_frame=0: timing and ram_addr continue unchanged; de and frame_start still toggle; rgb forced to 0 for the whole frame.
  - Changes mid-frame take effect at the next frame only (no tearing).
- Reset mid-frame: the next cycle after release restarts at (0,0). The first frame_start appears 3 cycles after release.
- Out-of-range: no other state; there is no illegal counter value because the counters only use their wrap values.

Optional Feature:
- Macro: FB_VIDEO_TEST_PATTERN_EN.
- Defined:
  - test_pat is latched at frame start like enable.
  - When latched high, active pixels output red=h[7:0], green=v[7:0], blue=h[7:0]^v[7:0] (counter values of that pixel, delayed 3 stages).
  - ram_addr sequencing is unchanged, and en_frame=0 still blanks.
- Undefined: test_pat port remains but is ignored; outputs are identical to the test_pat=0 case.

Decomposition:
- Package fb_video_pkg: default timing constants, H_TOTAL/V_TOTAL, WORDS_PER_LINE=160, WORDS_PER_FRAME=76800, PIPE_LAT=3.
- Sub-module video_timing_gen: owns h_cnt/v_cnt and produces raw active/hsync/vsync/frame-start flags. fb_video_reader adds the address pointer, lane select and the output pipeline.

Test Plan:
- Reset held 5 cycles -> all outputs at reset values during reset; hsync=vsync=1 with SYNC_ACT=0; first de rises 3 cycles after release.
- RAM model returns 0x44332211 for word 0 and 0x88776655 for word 1 -> first 8 de-cycle outputs are 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with r=g=b.
- Free run for 2 frames -> hsync low exactly 96 cycles every 800 cycles; vsync low 2 lines every 525 lines; de high 640 cycles per line for 480 lines; frame_start once every 420000 cycles.
- Monitor ram_addr -> increments once per 4 active pixels, reaches 76799 on the last word of the frame, and is 0 for the first word of the next frame.
- Drop enable at line 100 -> current frame unaffected; next frame rgb=0 with timing intact. Re-raise enable -> video resumes at the following frame.
- Assert reset 1 cycle at h=300, v=200 -> counters restart; frame_start 3 cycles after release; ram_addr=0. With the macro defined and test_pat=1: pixel (5,3) outputs red=5, green=3, blue=6.
